// File: rtl/serial_chunk_adder_if.sv
// Handshake and operand/result bundle for serial_chunk_adder.
// The master issues start/sub/a/b; the slave returns busy/done/sum/ovf.
interface serial_chunk_adder_if #(
  parameter int WIDTH = 20
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   sum;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, ovf
  );
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/sub: one CHUNK-bit ripple slice per clock, carry held between slices.
// state | meaning:  IDLE | waiting for start,  RUN | one slice per clock,  DONE | result valid for one cycle
module serial_chunk_adder #(
  parameter int WIDTH = 20,
  parameter int CHUNK = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  serial_chunk_adder_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    carry_q;
  logic [N-1:0][CHUNK-1:0] a_q;
  logic [N-1:0][CHUNK-1:0] b_q;
  logic [N-1:0][CHUNK-1:0] sum_q;
  logic                    cout_q;
  logic                    ovf_q;
  logic                    busy_q;
  logic                    done_q;

  logic [CHUNK:0]          slice_d;
  logic                    last_d;

  always_comb begin
    slice_d = {1'b0, a_q[cnt_q]} + {1'b0, b_q[cnt_q]} + {{CHUNK{1'b0}}, carry_q};
    last_d  = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q[cnt_q] <= slice_d[CHUNK-1:0];
          carry_q      <= slice_d[CHUNK];
          if (last_d) begin
            cnt_q   <= '0;
            cout_q  <= slice_d[CHUNK];
            ovf_q   <= (a_q[N-1][CHUNK-1] == b_q[N-1][CHUNK-1]) &&
                       (slice_d[CHUNK-1] != a_q[N-1][CHUNK-1]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = {cout_q, sum_q};
  assign bus.ovf  = ovf_q;
endmodule
